// File: rtl/rv32v_mem_deserializer_if.sv
// Bundles the LSC response channel and the writeback handshake of the vector load deserializer.
// slave = the deserializer; master = the LSC/writeback side driving responses and wb_ready.
interface rv32v_mem_deserializer_if #(
  parameter int NUM_LANES = 4,
  parameter int WORD_W    = 32
);
  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  logic                              rsp_valid;
  logic [LANE_W-1:0]                 rsp_lane;
  logic [WORD_W-1:0]                 rsp_data;
  logic [1:0]                        rsp_byte_off;
  logic                              wb_valid;
  logic                              wb_ready;
  logic [NUM_LANES-1:0][WORD_W-1:0]  wb_data;
  logic [NUM_LANES-1:0]              wb_misaligned;

  modport master (
    output rsp_valid, rsp_lane, rsp_data, rsp_byte_off, wb_ready,
    input  wb_valid, wb_data, wb_misaligned
  );

  modport slave (
    input  rsp_valid, rsp_lane, rsp_data, rsp_byte_off, wb_ready,
    output wb_valid, wb_data, wb_misaligned
  );
endinterface

// File: rtl/rv32v_mem_deserializer.sv
// Gathers per-lane LSC load responses, extracts/zero-extends each element to SEW and
// assembles one NUM_LANES-wide writeback vector per load micro-op.
//   state   | meaning
//   IDLE    | waiting for start; responses here are protocol errors
//   COLLECT | accepting one response per cycle for unreceived active lanes
//   DONE    | vector valid, held until wb_ready
module rv32v_mem_deserializer #(
  parameter int NUM_LANES = 4,
  parameter int WORD_W    = 32
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             start,
  input  logic [NUM_LANES-1:0]             vlane_mask,
  input  logic [1:0]                       veew,
  input  logic [NUM_LANES-1:0][WORD_W-1:0] vold_data,
  rv32v_mem_deserializer_if.slave          bus,
  output logic                             collect_stall,
  output logic                             proto_err
);
  localparam logic [1:0] SEW8  = 2'b00;
  localparam logic [1:0] SEW16 = 2'b01;

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t                            state, state_nxt;
  logic [NUM_LANES-1:0]              mask, got, misal, lane_sel, got_nxt;
  logic [1:0]                        eew;
  logic [NUM_LANES-1:0][WORD_W-1:0]  data;
  logic                              take_start, take_rsp, rsp_err, rsp_mis;
  logic [WORD_W-1:0]                 shifted, element;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    take_start = 1'b0;
    take_rsp   = 1'b0;
    lane_sel   = '0;
    lane_sel[bus.rsp_lane] = 1'b1;
    got_nxt    = got | lane_sel;
    case (state)
      IDLE: begin
        if (start) begin
          take_start = 1'b1;
          state_nxt  = (vlane_mask == '0) ? DONE : COLLECT;
        end
      end
      COLLECT: begin
        if (bus.rsp_valid && mask[bus.rsp_lane] && !got[bus.rsp_lane]) begin
          take_rsp = 1'b1;
          if ((got_nxt | ~mask) == '1) state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.wb_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Anything not accepted in COLLECT is unexpected, including a response alongside start.
    rsp_err       = bus.rsp_valid & ~take_rsp;
    collect_stall = (state == COLLECT) | ((state == DONE) & ~bus.wb_ready) |
                    ((state == IDLE) & start & (|vlane_mask));
  end

  always_comb begin
    shifted = bus.rsp_data >> {bus.rsp_byte_off, 3'b000};
    rsp_mis = 1'b0;
    element = bus.rsp_data;
    case (eew)
      SEW8:  element = {{(WORD_W-8){1'b0}}, shifted[7:0]};
      SEW16: begin
        rsp_mis = bus.rsp_byte_off[0];
        element = rsp_mis ? '0 : {{(WORD_W-16){1'b0}}, shifted[15:0]};
      end
      default: begin
        rsp_mis = |bus.rsp_byte_off;
        element = rsp_mis ? '0 : bus.rsp_data;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mask      <= '0;
      eew       <= SEW8;
      got       <= '0;
      misal     <= '0;
      data      <= '0;
      proto_err <= 1'b0;
    end else begin
      proto_err <= rsp_err;
      if (take_start) begin
        mask  <= vlane_mask;
        eew   <= veew;
        got   <= '0;
        misal <= '0;
        // Active lanes are cleared so nothing from a previous op can leak through.
        for (int i = 0; i < NUM_LANES; i++)
          data[i] <= vlane_mask[i] ? '0 : vold_data[i];
      end else if (take_rsp) begin
        got                  <= got_nxt;
        misal[bus.rsp_lane]  <= rsp_mis;
        data[bus.rsp_lane]   <= element;
      end
    end
  end

  assign bus.wb_valid      = (state == DONE);
  assign bus.wb_data       = data;
  assign bus.wb_misaligned = misal;
endmodule

// File: tb/tb_rv32v_mem_deserializer.sv
// Scoreboard bench for rv32v_mem_deserializer: a lane model builds the expected vector,
// which is queued when the op's last response is driven and checked at the wb handshake.
module tb_rv32v_mem_deserializer;
  localparam int NL = 4;
  localparam int W  = 32;
  localparam logic [1:0] E8 = 2'd0, E16 = 2'd1, E32 = 2'd2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     start;
  logic [NL-1:0]            vlane_mask;
  logic [1:0]               veew;
  logic [NL-1:0][W-1:0]     vold_data;
  logic                     collect_stall;
  logic                     proto_err;

  rv32v_mem_deserializer_if #(.NUM_LANES(NL), .WORD_W(W)) ifc ();

  rv32v_mem_deserializer #(.NUM_LANES(NL), .WORD_W(W)) dut (
    .CLK(clk), .RST(rst), .start(start), .vlane_mask(vlane_mask), .veew(veew),
    .vold_data(vold_data), .bus(ifc.slave), .collect_stall(collect_stall), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NL*W-1:0] data;
    logic [NL-1:0]   mis;
  } exp_t;

  exp_t                 sb[$];
  exp_t                 popped;
  int                   n_chk = 0;
  int                   n_fail = 0;
  logic [NL-1:0][W-1:0] m_data;
  logic [NL-1:0]        m_mis, m_mask, m_got;
  logic [1:0]           m_eew;

  task automatic chk(input string tag, input logic [NL*W-1:0] obs, input logic [NL*W-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns {misaligned, element}; byte selection written independently of the shift form.
  function automatic logic [W:0] m_extract(input logic [1:0] eew, input logic [1:0] off,
                                           input logic [W-1:0] d);
    logic [7:0] b [4];
    b[0] = d[7:0]; b[1] = d[15:8]; b[2] = d[23:16]; b[3] = d[31:24];
    case (eew)
      E8:  return {1'b0, 24'h0, b[off]};
      E16: begin
        if (off[0]) return {1'b1, 32'h0};
        return {1'b0, 16'h0, b[off + 2'd1], b[off]};
      end
      default: begin
        if (off != 2'd0) return {1'b1, 32'h0};
        return {1'b0, d};
      end
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst && ifc.wb_valid && ifc.wb_ready) begin
      if (sb.size() == 0) chk("wb_unexpected", 1, 0);
      else begin
        popped = sb.pop_front();
        chk("wb_data", ifc.wb_data, popped.data);
        chk("wb_misaligned", ifc.wb_misaligned, popped.mis);
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic op_start(input logic [NL-1:0] mask, input logic [1:0] eew,
                          input logic [NL-1:0][W-1:0] old);
    start = 1'b1; vlane_mask = mask; veew = eew; vold_data = old;
    m_mask = mask; m_eew = eew; m_got = '0; m_mis = '0;
    for (int i = 0; i < NL; i++) m_data[i] = mask[i] ? '0 : old[i];
    if (mask == '0) sb.push_back({m_data, m_mis});
    #1;
    chk("stall_at_start", collect_stall, |mask);
    cyc();
    start = 1'b0;
  endtask

  task automatic send_rsp(input int lane, input logic [W-1:0] d, input logic [1:0] off,
                          input logic expect_err);
    logic [W:0] r;
    ifc.rsp_valid = 1'b1; ifc.rsp_lane = lane[1:0]; ifc.rsp_data = d; ifc.rsp_byte_off = off;
    if (!expect_err) begin
      r = m_extract(m_eew, off, d);
      m_data[lane] = r[W-1:0];
      m_mis[lane]  = r[W];
      m_got[lane]  = 1'b1;
      if ((m_got | ~m_mask) == '1) sb.push_back({m_data, m_mis});
    end
    cyc();
    ifc.rsp_valid = 1'b0;
    chk("proto_err", proto_err, expect_err);
  endtask

  task automatic finish_op();
    int n = 0;
    while (!ifc.wb_valid && n < 20) begin cyc(); n++; end
    chk("wb_valid_wait", ifc.wb_valid, 1);
    ifc.wb_ready = 1'b1;
    cyc();
    ifc.wb_ready = 1'b0;
    chk("wb_valid_drop", ifc.wb_valid, 0);
    chk("idle_stall", collect_stall, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NL-1:0][W-1:0] old;
    logic [NL-1:0]        rm;
    rst = 1'b1; start = 1'b0; vlane_mask = '0; veew = E32; vold_data = '0;
    ifc.rsp_valid = 1'b0; ifc.rsp_lane = '0; ifc.rsp_data = '0; ifc.rsp_byte_off = '0;
    ifc.wb_ready = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_wb_valid", ifc.wb_valid, 0);
    chk("rst_wb_data", ifc.wb_data, 0);
    chk("rst_wb_mis", ifc.wb_misaligned, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_stall", collect_stall, 0);

    send_rsp(0, 32'h1, 2'd0, 1'b1);

    // SEW32 in-order, wb_valid the cycle after the last response
    op_start(4'b1111, E32, '0);
    send_rsp(0, 32'h11111111, 2'd0, 1'b0);
    send_rsp(1, 32'h22222222, 2'd0, 1'b0);
    send_rsp(2, 32'h33333333, 2'd0, 1'b0);
    chk("no_early_valid", ifc.wb_valid, 0);
    send_rsp(3, 32'h44444444, 2'd0, 1'b0);
    chk("latency_valid", ifc.wb_valid, 1);
    chk("latency_data", ifc.wb_data, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
    finish_op();

    // SEW8 byte extraction
    op_start(4'b1111, E8, '0);
    for (int i = 0; i < NL; i++) send_rsp(i, 32'hAABBCCDD, i[1:0], 1'b0);
    finish_op();

    // Partial mask, out-of-order, masked-off and duplicate responses
    old = {32'hDEAD0003, 32'hDEAD0002, 32'hDEAD0001, 32'hDEAD0000};
    op_start(4'b0101, E32, old);
    send_rsp(2, 32'h22220000, 2'd0, 1'b0);
    send_rsp(1, 32'h99999999, 2'd0, 1'b1);
    send_rsp(2, 32'h77777777, 2'd0, 1'b1);
    chk("err_no_complete", ifc.wb_valid, 0);
    send_rsp(0, 32'h00001111, 2'd0, 1'b0);
    finish_op();

    // Empty mask: immediate DONE, held while wb_ready low
    old = {32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000};
    op_start(4'b0000, E32, old);
    for (int k = 0; k < 3; k++) begin
      chk("hold_valid", ifc.wb_valid, 1);
      chk("hold_data", ifc.wb_data, old);
      chk("hold_stall", collect_stall, 1);
      send_rsp(1, 32'h5, 2'd0, 1'b1);
    end
    finish_op();

    // Misalignment
    op_start(4'b0011, E16, '0);
    send_rsp(0, 32'h12345678, 2'd1, 1'b0);
    send_rsp(1, 32'h12345678, 2'd2, 1'b0);
    finish_op();
    op_start(4'b0011, E32, '0);
    send_rsp(0, 32'h87654321, 2'd0, 1'b0);
    send_rsp(1, 32'h87654321, 2'd2, 1'b0);
    chk("mis32", ifc.wb_misaligned, 4'b0010);
    finish_op();

    // Reset mid-collection, then a clean op
    op_start(4'b1111, E32, '0);
    send_rsp(0, 32'hAAAA0000, 2'd0, 1'b0);
    send_rsp(1, 32'hBBBB0000, 2'd0, 1'b0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    sb.delete();
    chk("abort_valid", ifc.wb_valid, 0);
    chk("abort_data", ifc.wb_data, 0);
    chk("abort_stall", collect_stall, 0);
    op_start(4'b1111, E16, '0);
    send_rsp(3, 32'h0000BEEF, 2'd0, 1'b0);
    send_rsp(0, 32'hF00D0000, 2'd2, 1'b0);
    send_rsp(1, 32'h00ABCD00, 2'd1, 1'b0);
    send_rsp(2, 32'h12340000, 2'd2, 1'b0);
    finish_op();

    // Random ops, including the reserved width encoding
    for (int t = 0; t < 8; t++) begin
      rm = 4'($urandom_range(0, 15));
      for (int i = 0; i < NL; i++) old[i] = $urandom;
      op_start(rm, 2'($urandom_range(0, 3)), old);
      for (int i = NL - 1; i >= 0; i--)
        if (rm[i]) send_rsp(i, $urandom, 2'($urandom_range(0, 3)), 1'b0);
      finish_op();
    end

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
